// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIN  = 2'b10
   } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake, operand and result bundle between the control unit and the subtractor.
interface serial_subtractor_if
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] d;
   logic             bo;
   logic             v;
   logic             z;
   logic             busy;
   logic             done;

   modport master (
      output start, a, b,
      input  d, bo, v, z, busy, done
   );

   modport slave (
      input  start, a, b,
      output d, bo, v, z, busy, done
   );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: two half subtractors chained, borrows ORed together.
module full_subtractor (
   output logic d,
   output logic bo,
   input  logic a,
   input  logic b,
   input  logic bi
);

   logic half_d;
   logic half_bo;
   logic carry_bo;

   always_comb begin
      half_d   = a ^ b;
      half_bo  = ~a & b;
      carry_bo = ~half_d & bi;
      d        = half_d ^ bi;
      bo       = half_bo | carry_bo;
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B, one bit per clock, LSB first.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   serial_subtractor_if.slave  bus
);

   localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-2:0] p;
   logic [WIDTH-1:0] final_p;
   logic [CW-1:0]    count;
   logic             borrow;
   logic             diff_bit;
   logic             borrow_next;
   logic             load;
   logic             last_bit;

   full_subtractor u_cell (
      .d  (diff_bit),
      .bo (borrow_next),
      .a  (sa[0]),
      .b  (sb[0]),
      .bi (borrow)
   );

   // Partial difference including the bit produced this cycle; on the last
   // RUN edge this is the complete result.
   assign final_p = {diff_bit, p};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      last_bit   = 1'b0;
      bus.busy   = 1'b0;
      bus.done   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            bus.busy = 1'b1;
            if (count == LAST) begin
               last_bit   = 1'b1;
               state_next = FIN;
            end
         end
         FIN: begin
            bus.done = 1'b1;
            if (bus.start) begin
               load       = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Result registers only change on the final RUN edge, so they hold steady
   // while the next operation is being computed. The MSB's borrow-in is the
   // current borrow on that edge, giving overflow as borrow-in XOR borrow-out.
   always_ff @(posedge clk) begin
      if (rst) begin
         sa     <= '0;
         sb     <= '0;
         p      <= '0;
         count  <= '0;
         borrow <= 1'b0;
         bus.d  <= '0;
         bus.bo <= 1'b0;
         bus.v  <= 1'b0;
         bus.z  <= 1'b0;
      end else if (load) begin
         sa     <= bus.a;
         sb     <= bus.b;
         count  <= '0;
         borrow <= 1'b0;
      end else if (state == RUN) begin
         sa     <= sa >> 1;
         sb     <= sb >> 1;
         p      <= final_p[WIDTH-1:1];
         borrow <= borrow_next;
         count  <= count + 1'b1;
         if (last_bit) begin
            bus.d  <= final_p;
            bus.bo <= borrow_next;
            bus.v  <= borrow ^ borrow_next;
            bus.z  <= (final_p == '0);
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for the bit-serial subtractor at WIDTH=8: vector table plus protocol sequences.
module tb_serial_subtractor;
   import serial_subtractor_pkg::*;

   localparam int W     = 8;
   localparam int BOUND = 40;

   logic clk = 1'b0;
   logic rst;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] d;
      logic         bo;
      logic         v;
      logic         z;
   } vec_t;

   vec_t vecs[5];

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Present operands with START high ahead of the next rising edge.
   task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
   endtask

   // Samples once per cycle after the accepting edge; returns the cycle index
   // at which DONE was seen (-1 on timeout) and how many cycles BUSY was high.
   task automatic wait_done(input bit drop_start, output int latency, output int busy_cnt);
      latency  = -1;
      busy_cnt = 0;
      for (int j = 0; j < BOUND; j++) begin
         @(negedge clk);
         if (j == 0 && drop_start) bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            latency = j;
            break;
         end
         if (bus.busy === 1'b1) busy_cnt++;
      end
      if (latency < 0) begin
         failures++;
         checks++;
         $display("[TB] FAIL done_timeout: got no DONE, expected DONE within %0d cycles", BOUND);
      end
   endtask

   initial begin
      int lat;
      int bc;
      int extra_done;

      vecs[0] = '{a: 8'h05, b: 8'h03, d: 8'h02, bo: 1'b0, v: 1'b0, z: 1'b0};
      vecs[1] = '{a: 8'h03, b: 8'h05, d: 8'hFE, bo: 1'b1, v: 1'b0, z: 1'b0};
      vecs[2] = '{a: 8'h80, b: 8'h01, d: 8'h7F, bo: 1'b0, v: 1'b1, z: 1'b0};
      vecs[3] = '{a: 8'h7F, b: 8'hFF, d: 8'h80, bo: 1'b1, v: 1'b1, z: 1'b0};
      vecs[4] = '{a: 8'h5A, b: 8'h5A, d: 8'h00, bo: 1'b0, v: 1'b0, z: 1'b1};

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      check_output("reset_d",    bus.d,    0);
      check_output("reset_bo",   bus.bo,   0);
      check_output("reset_v",    bus.v,    0);
      check_output("reset_z",    bus.z,    0);
      check_output("reset_busy", bus.busy, 0);
      check_output("reset_done", bus.done, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         apply_stimulus(vecs[i].a, vecs[i].b);
         wait_done(1'b1, lat, bc);
         check_output($sformatf("v%0d_latency", i), lat, W);
         check_output($sformatf("v%0d_busy_cycles", i), bc, W);
         check_output($sformatf("v%0d_d", i),  bus.d,  vecs[i].d);
         check_output($sformatf("v%0d_bo", i), bus.bo, vecs[i].bo);
         check_output($sformatf("v%0d_v", i),  bus.v,  vecs[i].v);
         check_output($sformatf("v%0d_z", i),  bus.z,  vecs[i].z);
         @(negedge clk);
         check_output($sformatf("v%0d_done_pulse", i), bus.done, 0);
         check_output($sformatf("v%0d_d_hold", i), bus.d, vecs[i].d);
      end

      // START held high through RUN while the operands churn.
      apply_stimulus(8'h20, 8'h05);
      lat = -1;
      for (int j = 0; j < BOUND; j++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            lat       = j;
            bus.start = 1'b0;
            break;
         end
         bus.a = W'($urandom);
         bus.b = W'($urandom);
      end
      check_output("held_latency", lat, W);
      check_output("held_d", bus.d, 8'h1B);
      extra_done = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done === 1'b1) extra_done++;
      end
      check_output("held_single_done", extra_done, 0);

      // Back-to-back: new START accepted in the FIN cycle.
      apply_stimulus(8'h05, 8'h03);
      wait_done(1'b1, lat, bc);
      check_output("b2b_first_d", bus.d, 8'h02);
      bus.a     = 8'h10;
      bus.b     = 8'h01;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check_output("b2b_no_gap_busy", bus.busy, 1);
      check_output("b2b_d_held_in_run", bus.d, 8'h02);
      wait_done(1'b0, lat, bc);
      check_output("b2b_latency", lat, W - 1);
      check_output("b2b_second_d", bus.d, 8'h0F);
      check_output("b2b_second_bo", bus.bo, 0);

      // Reset during RUN aborts the operation and clears the results.
      apply_stimulus(8'h33, 8'h11);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         if (j == 0) bus.start = 1'b0;
      end
      check_output("abort_busy_before", bus.busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_output("abort_d",    bus.d,    0);
      check_output("abort_bo",   bus.bo,   0);
      check_output("abort_v",    bus.v,    0);
      check_output("abort_z",    bus.z,    0);
      check_output("abort_busy", bus.busy, 0);
      check_output("abort_done", bus.done, 0);
      extra_done = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done === 1'b1) extra_done++;
      end
      check_output("abort_no_done", extra_done, 0);
      apply_stimulus(8'h80, 8'h01);
      wait_done(1'b1, lat, bc);
      check_output("after_abort_latency", lat, W);
      check_output("after_abort_d", bus.d, 8'h7F);
      check_output("after_abort_v", bus.v, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, bit-serial two's-complement subtractor. Computes D = A - B one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Functional inverse of the ripple adder datapath. Used in the ALU where area matters more than latency.
- Start/done handshake toward the control unit.
- Result registers update only at completion.

Parameters:
- WIDTH, 32, operand and result width in bits (legal range 2..64).

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only when BUSY=0.
- A  input  WIDTH  minuend; captured on the accepting edge.
- B  input  WIDTH  subtrahend; captured on the accepting edge.
- D  output  WIDTH  difference A-B (mod 2^WIDTH).
- BO  output  1  borrow out of MSB (unsigned A<B).
- V  output  1  signed overflow.
- Z  output  1  D==0.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle pulse when result registers update.

Behaviour:
- States: IDLE, RUN, FIN. Reset state is IDLE.
- Reset (RST=1 at an edge) overrides everything. Next values: state=IDLE, D=0, BO=0, V=0, Z=0, BUSY=0, DONE=0, shift regs=0, bit counter=0, borrow=0. A reset during RUN aborts the operation: no DONE pulse, result registers cleared.
- IDLE or FIN with START=1: A and B load into shift registers SA and SB, borrow=0, counter=0, next state RUN.
- IDLE with START=0: stay in IDLE.
- FIN with START=0: next state IDLE.
- RUN, each edge:
  - d = SA[0]^SB[0]^borrow.
  - bnext = (~SA[0]&SB[0]) | (~(SA[0]^SB[0])&borrow).
  - SA and SB shift right. d shifts into the MSB of the partial-difference register P.
  - borrow <= bnext; counter++.
  - On the edge where counter == WIDTH-1, record the borrow-in of the MSB (for V) and go to FIN.
- Entering FIN, all of these update on the same edge:
  - D <= final P.
  - BO <= final borrow out.
  - V <= borrow-in(MSB) XOR borrow-out(MSB).
  - Z <= (final P == 0).
- DONE=1 exactly while in FIN (one cycle).
- BUSY=1 exactly while in RUN.
- Latency: START accepted at edge k → DONE high in the cycle following edge k+WIDTH. D/BO/V/Z are valid in that cycle.
- START while BUSY=1 is ignored. It is not queued, and A/B changes are ignored.
- Back-to-back: START=1 during the FIN cycle is accepted with no idle gap. Throughput is one result per WIDTH+1 cycles.
- D, BO, V and Z hold their last values from FIN until the next FIN or reset. They do not toggle during RUN.
- A and B are sampled only at the accepting edge. Changing them afterwards has no effect.
- Counter width is clog2(WIDTH). No wrap-around beyond WIDTH-1 is reachable.

Decomposition:
- Shared package/header: state encodings (IDLE=2'b00, RUN=2'b01, FIN=2'b10) and default WIDTH as constants. Place them alongside the existing project definitions include.
- Sub-module: full_subtractor (ports D, BO, A, B, BI). Purely combinational 1-bit cell, instantiated once. Built from two half-subtractor equations plus an OR, mirroring the full-adder structure.
- Everything else (FSM, counter, shift regs, result regs) lives in serial_subtractor.

Test Plan:
All scenarios use WIDTH=8.
- A=0x05, B=0x03, one-cycle START → D=0x02, BO=0, V=0, Z=0. DONE high for exactly one cycle, 8 cycles after the START edge. BUSY high for 8 cycles.
- A=0x03, B=0x05 → D=0xFE, BO=1, V=0, Z=0.
- A=0x80, B=0x01 → D=0x7F, BO=0, V=1.
- A=0x7F, B=0xFF → D=0x80, BO=1, V=1.
- A=0x5A, B=0x5A → D=0x00, Z=1, BO=0, V=0.
- Protocol cases:
  - START held high through RUN with A/B changing each cycle → only the first operands are used; one DONE per accepted START.
  - START asserted in the FIN cycle with A=0x10, B=0x01 → the new op starts with no gap; D=0x0F.
  - RST=1 at cycle 4 of RUN → next cycle all outputs are 0 and state is IDLE, with no DONE. A subsequent START completes normally.
